// File: rtl/mpmc9_rd_strip_collect.sv
// -----------------------------------------------------------------------------
// mpmc9_rd_strip_collect
//
// Purpose:
//   Downstream companion of the app_en generator. Tracks read commands that the
//   MIG accepts, collects the returned app_rd_data beats (one per strip) into a
//   small return FIFO and hands them to the channel read-return path over a
//   valid/ready handshake, tagged with the strip index. Pulses done once the
//   last strip of a burst has been taken by the consumer. Protocol faults are
//   reported as sticky error flags that only reset clears.
//
// Parameters:
//   WID       MIG app data width in bits (one strip per beat)
//   FIFO_DEP  return FIFO depth in strips (power of two, >= 2)
//   OCW       outstanding-command counter width
//
// Ports:
//   clk, rstn            controller clock, asynchronous active-low reset
//   start, num_strips    burst start pulse and last strip index of the burst
//   app_en/app_rdy/app_cmd  MIG command interface (observed only)
//   rd_data, rd_data_valid  MIG read return (cannot be stalled)
//   o_data, o_idx, o_valid, o_ready  strip return handshake
//   done                 one-cycle pulse after the last strip is accepted
//   busy                 collector is not idle
//   err_orphan           sticky: data beat with no outstanding read
//   err_ovf              sticky: data beat arrived while the FIFO was full
//   err_tmo              sticky: collect watchdog expired
//
// Configuration:
//   MPMC9_RD_TIMEOUT_EN  when defined, a 10-bit watchdog aborts a stalled
//                        collect phase and raises err_tmo; otherwise err_tmo
//                        is tied low and no watchdog logic exists.
// -----------------------------------------------------------------------------
module mpmc9_rd_strip_collect #(
    parameter int WID      = 128,
    parameter int FIFO_DEP = 4,
    parameter int OCW      = 7
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic [5:0]     num_strips,
    input  logic           app_en,
    input  logic           app_rdy,
    input  logic [2:0]     app_cmd,
    input  logic [WID-1:0] rd_data,
    input  logic           rd_data_valid,
    output logic [WID-1:0] o_data,
    output logic [5:0]     o_idx,
    output logic           o_valid,
    input  logic           o_ready,
    output logic           done,
    output logic           busy,
    output logic           err_orphan,
    output logic           err_ovf,
    output logic           err_tmo
);

    localparam int         PW       = $clog2(FIFO_DEP);
    localparam int         CW       = PW + 1;
    localparam logic [2:0] CMD_READ = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_ns;
    logic [5:0]       r_in_idx;
    logic [OCW-1:0]   r_outst;
    logic [WID-1:0]   r_mem [FIFO_DEP];
    logic [5:0]       r_tag [FIFO_DEP];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_done;
    logic             r_err_orphan;
    logic             r_err_ovf;

    logic             w_acc;
    logic             w_collect_beat;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_tmo;

    assign w_acc          = app_en && app_rdy && (app_cmd == CMD_READ);
    assign w_collect_beat = rd_data_valid && (r_state == S_COLLECT);
    assign w_full         = (r_count == CW'(FIFO_DEP));
    assign w_empty        = (r_count == '0);
    // A full FIFO rejects the beat even if the consumer pops this cycle.
    assign w_push         = w_collect_beat && !w_full;
    assign w_pop          = !w_empty && o_ready;

`ifdef MPMC9_RD_TIMEOUT_EN
    logic [9:0] r_wdog;
    logic       r_err_tmo;

    // Counts stalled collect cycles; any beat or leaving COLLECT restarts it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog    <= '0;
            r_err_tmo <= 1'b0;
        end else begin
            if ((r_state != S_COLLECT) || rd_data_valid)
                r_wdog <= '0;
            else if (r_outst != '0)
                r_wdog <= r_wdog + 1'b1;
            if (w_tmo)
                r_err_tmo <= 1'b1;
        end
    end

    assign w_tmo   = (r_state == S_COLLECT) && (r_wdog == 10'h3FF);
    assign err_tmo = r_err_tmo;
`else
    assign w_tmo   = 1'b0;
    assign err_tmo = 1'b0;
`endif

    // DRAIN ends when the last stored strip leaves; this also covers bursts
    // whose final strip was dropped on overflow, which then end without done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_collect_beat && (r_in_idx == r_ns))
                    w_next = S_DRAIN;
                else if (w_tmo)
                    w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (w_pop && (r_count == CW'(1)))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_ns     <= '0;
            r_in_idx <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && start) begin
                r_ns     <= num_strips;
                r_in_idx <= '0;
            end else if (w_collect_beat) begin
                r_in_idx <= r_in_idx + 1'b1;
            end
        end
    end

    // Outstanding reads: accept and beat together cancel; saturate both ways.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outst <= '0;
        end else begin
            case ({w_acc, rd_data_valid})
                2'b10: if (r_outst != {OCW{1'b1}}) r_outst <= r_outst + 1'b1;
                2'b01: if (r_outst != '0)          r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rd_data;
            r_tag[r_wr_ptr] <= r_in_idx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done       <= 1'b0;
            r_err_orphan <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_pop && (r_tag[r_rd_ptr] == r_ns);
            if (rd_data_valid && (r_outst == '0))
                r_err_orphan <= 1'b1;
            if (w_collect_beat && w_full)
                r_err_ovf <= 1'b1;
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_idx      = w_empty ? '0 : r_tag[r_rd_ptr];
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);
    assign err_orphan = r_err_orphan;
    assign err_ovf    = r_err_ovf;

endmodule
